// File: rtl/mux_scan_controller.sv
// Round-robin scanner for a 4:1 multiplexer: walks the enabled channels in
// ascending order, dwells on each select, and captures the mux output per channel.
module mux_scan_controller #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] en_mask,
  input  logic       y_in,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state_r, state_s;
  logic [3:0] mask_r, mask_s;
  logic [3:0] sample_r, sample_s;
  logic [7:0] cnt_r, cnt_s;
  logic [1:0] sel_r, sel_s;
  logic       busy_r, done_r;
  logic [2:0] first_chan_s, next_chan_s;

  // Lowest enabled channel at or above 'from'; bit 2 set means none remains.
  function automatic logic [2:0] find_chan(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      res = (mask[i] && (3'(i) >= from)) ? {1'b0, 2'(i)} : res;
    end
    return res;
  endfunction

  assign first_chan_s = find_chan(en_mask, 3'd0);
  assign next_chan_s  = find_chan(mask_r, {1'b0, sel_r} + 3'd1);

  // Next-state and datapath update for the scan sequence.
  always_comb begin
    state_s  = state_r;
    mask_s   = mask_r;
    sample_s = sample_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    case (state_r)
      IDLE: begin
        sel_s = 2'b00;
        if (start) begin
          sample_s = 4'b0000;
          if (en_mask != 4'b0000) begin
            mask_s  = en_mask;
            sel_s   = first_chan_s[1:0];
            cnt_s   = DWELL_M1;
            state_s = SCAN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else begin
          // Capture and advance on the same edge so the mux settles for DWELL full cycles.
          sample_s[sel_r] = y_in;
          if (!next_chan_s[2]) begin
            sel_s = next_chan_s[1:0];
            cnt_s = DWELL_M1;
          end else begin
            sel_s   = 2'b00;
            state_s = DONE;
          end
        end
      end
      DONE: begin
        sel_s   = 2'b00;
        state_s = IDLE;
      end
      default: begin
        sel_s   = 2'b00;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mask_r   <= 4'b0000;
      sample_r <= 4'b0000;
      cnt_r    <= 8'd0;
      sel_r    <= 2'b00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mask_r   <= mask_s;
      sample_r <= sample_s;
      cnt_r    <= cnt_s;
      sel_r    <= sel_s;
      busy_r   <= (state_s == SCAN);
      done_r   <= (state_s == DONE);
    end
  end

  assign s1     = sel_r[1];
  assign s0     = sel_r[0];
  assign busy   = busy_r;
  assign done   = done_r;
  assign sample = sample_r;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench: two scanners (DWELL=4 and DWELL=1) each driving a
// behavioural 4:1 mux, checked cycle by cycle against a channel-list model.
module tb_mux_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] mask_a = 4'b0000, mask_b = 4'b0000;
  logic [3:0] ins_a = 4'b0000, ins_b = 4'b0000;
  logic       y_a, y_b;
  logic       s1_a, s0_a, busy_a, done_a;
  logic       s1_b, s0_b, busy_b, done_b;
  logic [3:0] sample_a, sample_b;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign y_a = ins_a[{s1_a, s0_a}];
  assign y_b = ins_b[{s1_b, s0_b}];

  mux_scan_controller #(.DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .en_mask(mask_a), .y_in(y_a),
    .s1(s1_a), .s0(s0_a), .busy(busy_a), .done(done_a), .sample(sample_a)
  );

  mux_scan_controller #(.DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .en_mask(mask_b), .y_in(y_b),
    .s1(s1_b), .s0(s0_b), .busy(busy_b), .done(done_b), .sample(sample_b)
  );

  task automatic check(input string tag, input int d, input int c,
                       input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, d, c, obs, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_mask(input int d, input logic [3:0] m);
    if (d == 0) mask_a = m; else mask_b = m;
  endtask

  task automatic set_ins(input int d, input logic [3:0] v);
    if (d == 0) ins_a = v; else ins_b = v;
  endtask

  function automatic logic [3:0] get_sel(input int d);
    return (d == 0) ? {2'b00, s1_a, s0_a} : {2'b00, s1_b, s0_b};
  endfunction

  function automatic logic [3:0] get_busy(input int d);
    return (d == 0) ? {3'b000, busy_a} : {3'b000, busy_b};
  endfunction

  function automatic logic [3:0] get_done(input int d);
    return (d == 0) ? {3'b000, done_a} : {3'b000, done_b};
  endfunction

  function automatic logic [3:0] get_sample(input int d);
    return (d == 0) ? sample_a : sample_b;
  endfunction

  // Runs one scan from IDLE and checks every cycle up to and including the idle
  // cycle after done. With keep set, start stays high for a back-to-back scan.
  task automatic run_scan(input int d, input logic [3:0] mask, input logic [3:0] ins,
                          input bit perturb, input bit keep);
    int dw;
    int n;
    int cap;
    int chans[$];
    logic [3:0] es, eb, ed, esmp;
    dw = (d == 0) ? 4 : 1;
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
    n = chans.size();
    set_start(d, 1'b1);
    set_mask(d, mask);
    set_ins(d, ins);
    for (int c = 0; c <= n * dw + 1; c++) begin
      @(negedge clk);
      if (!keep) set_start(d, 1'b0);
      if (perturb && c == 1) begin
        set_start(d, 1'b1);
        set_mask(d, ~mask);
      end
      if (perturb && c == 2) set_start(d, keep);
      if (c < n * dw) begin
        es = 4'(chans[c / dw]); eb = 4'd1; ed = 4'd0; cap = c / dw;
      end else if (c == n * dw) begin
        es = 4'd0; eb = 4'd0; ed = 4'd1; cap = n;
      end else begin
        es = 4'd0; eb = 4'd0; ed = 4'd0; cap = n;
      end
      esmp = 4'b0000;
      for (int k = 0; k < cap; k++) esmp[chans[k]] = ins[chans[k]];
      check("sel", d, c, get_sel(d), es);
      check("busy", d, c, get_busy(d), eb);
      check("done", d, c, get_done(d), ed);
      check("sample", d, c, get_sample(d), esmp);
    end
  endtask

  initial begin
    logic [3:0] rm, ri;
    int d;
    repeat (2) @(negedge clk);
    for (int d0 = 0; d0 < 2; d0++) begin
      check("rst_sel", d0, 0, get_sel(d0), 4'd0);
      check("rst_busy", d0, 0, get_busy(d0), 4'd0);
      check("rst_done", d0, 0, get_done(d0), 4'd0);
      check("rst_sample", d0, 0, get_sample(d0), 4'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(0, 4'b1111, 4'b1010, 1'b0, 1'b0);   // full scan
    run_scan(0, 4'b0101, 4'b0101, 1'b0, 1'b0);   // sparse mask
    run_scan(0, 4'b0000, 4'b1111, 1'b0, 1'b0);   // empty mask
    run_scan(0, 4'b1011, 4'b0110, 1'b1, 1'b0);   // start/en_mask changed mid-scan
    run_scan(0, 4'b0110, 4'b0100, 1'b0, 1'b1);   // start held: back-to-back
    run_scan(0, 4'b1001, 4'b1000, 1'b1, 1'b1);
    run_scan(0, 4'b1111, 4'b0101, 1'b0, 1'b0);
    run_scan(1, 4'b1111, 4'b1010, 1'b0, 1'b0);   // minimum dwell
    run_scan(1, 4'b1111, 4'b0101, 1'b0, 1'b1);
    run_scan(1, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run_scan(1, 4'b1000, 4'b1000, 1'b0, 1'b0);

    // Asynchronous reset while channel 2 is selected.
    start_a = 1'b1; mask_a = 4'b1111; ins_a = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("pre_rst_sel", 0, 9, get_sel(0), 4'd2);
    check("pre_rst_sample", 0, 9, get_sample(0), 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 0, 9, get_sel(0), 4'd0);
    check("arst_busy", 0, 9, get_busy(0), 4'd0);
    check("arst_done", 0, 9, get_done(0), 4'd0);
    check("arst_sample", 0, 9, get_sample(0), 4'd0);
    @(negedge clk);
    check("rst_hold_done", 0, 10, get_done(0), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, 4'b1111, 4'b0110, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      d  = i % 2;
      rm = 4'($urandom_range(0, 15));
      ri = 4'($urandom_range(0, 15));
      run_scan(d, rm, ri, (d == 0) && (rm != 4'b0000) && (i % 3 == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
